seed_hit_detector: RTL
======================

// Module: seed_hit_detector
// PURPOSE
//   Downstream of the query/subject match array cell. Consumes per-cycle match flag plus
//   query_id/sub_id, tracks consecutive matches on one diagonal (both ids +1 per step), and
//   reports a seed hit when the run reaches WORD_LEN characters. Hits queue in a FWFT FIFO
//   with valid/ready handshake toward the ungapped-extension stage.
// PARAMETERS
//   LENGTH_COUNTER  8   width of query_id/sub_id and hit positions
//   WORD_LEN        11  seed length in matches; legal range 1..2**LENGTH_COUNTER-1
//   FIFO_DEPTH      8   hit FIFO entries; power of two, >=2
// PORTS
//   com_clk        in   1                     clock, rising edge
//   reset          in   1                     asynchronous, active-high
//   match          in   1                     match flag from array cell, this cycle
//   query_id       in   LENGTH_COUNTER        query position of the match
//   sub_id         in   LENGTH_COUNTER        subject position of the match
//   hit_valid      out  1                     FIFO head holds a hit
//   hit_ready      in   1                     consumer accepts head this cycle
//   hit_query_pos  out  LENGTH_COUNTER        seed start, query side (FIFO head)
//   hit_sub_pos    out  LENGTH_COUNTER        seed start, subject side (FIFO head)
//   fifo_count     out  $clog2(FIFO_DEPTH)+1  entries held
//   overflow       out  1                     sticky: a hit was dropped on a full FIFO
// BEHAVIOUR
//   Reset (async, reset=1): run_len=0, last_q=0, last_s=0, FIFO empty; hit_valid=0,
//     hit_query_pos=0, hit_sub_pos=0, fifo_count=0, overflow=0. Reset mid-run or with a full
//     FIFO discards everything; the first edge after release is treated as a fresh start.
//   Run tracker (states IDLE: run_len==0, RUN: 0<run_len<WORD_LEN, SEEDED: run_len==WORD_LEN):
//     match=0                                          -> run_len<=0 (IDLE)
//     match=1, run_len!=0, query_id==last_q+1 and sub_id==last_s+1 (mod 2**LENGTH_COUNTER)
//                                                      -> run_len<=min(run_len+1,WORD_LEN)
//     match=1, otherwise (IDLE or diagonal break)      -> run_len<=1
//     on every match=1: last_q<=query_id, last_s<=sub_id.
//   Hit event: cycle where next run_len==WORD_LEN and current run_len!=WORD_LEN.
//     Start positions: query_id-(WORD_LEN-1), sub_id-(WORD_LEN-1), modulo 2**LENGTH_COUNTER
//     (id wrap-around is a continuous diagonal, not a break).
//     WORD_LEN==1: every match is a hit (fresh or continuing) unless held in SEEDED.
//   FIFO: push on hit event; pop when hit_valid&&hit_ready. hit_valid = (fifo_count!=0).
//     Latency: hit into an empty FIFO -> hit_valid=1 on the next edge (1 cycle).
//     Full + push + pop same cycle: push accepted, count unchanged.
//     Full + push, no pop: hit dropped, overflow<=1 (held until reset), count unchanged.
//     Empty + push: hit_valid low that cycle, so no pop; count becomes 1.
//     Head outputs stable while hit_valid=1 and hit_ready=0.
// CONFIGURATION
//   SEED_HIT_REARM_EN defined: on a hit event run_len<=0 instead of WORD_LEN, so an unbroken
//     diagonal emits one hit per WORD_LEN matches (non-overlapping seeds); SEEDED unused.
//   Undefined: run saturates in SEEDED; exactly one hit per unbroken diagonal run.
// TESTING (WORD_LEN=4, FIFO_DEPTH=4, LENGTH_COUNTER=8 unless stated)
//   Matches at (q,s)=(10,20),(11,21),(12,22),(13,23), hit_ready=1 -> one hit (10,20),
//     hit_valid high the cycle after (13,23); 3 more matches (14,24..) give no hit.
//   Matches (10,20),(11,21),(12,30),(13,31),(14,32),(15,33) -> one hit (12,30) only.
//   Wrap: matches (254,1),(255,2),(0,3),(1,4) -> hit (254,1).
//   hit_ready=0, six separated 4-match runs -> fifo_count=4, overflow=1, heads are
//     runs 1..4 in order; then hit_ready=1 drains 4 hits, hit_valid=0.
//   Assert reset mid-run after 3 matches, release, 1 more diagonal match -> no hit,
//     all outputs 0 during reset.
//   SEED_HIT_REARM_EN: 8 consecutive diagonal matches from (10,20) -> hits (10,20),(14,24).

Source files
------------

// File: rtl/seed_hit_detector.sv
// seed_hit_detector
//   Follows per-cycle match flags from the query/subject match array cell and tracks
//   how many consecutive matches lie on one diagonal. A diagonal step means both ids
//   advance by one, modulo 2**LENGTH_COUNTER.
//   When a run reaches WORD_LEN matches, the seed start positions are pushed into a
//   first-word-fall-through FIFO. The FIFO drives a valid/ready handshake toward the
//   ungapped-extension stage.
//   Optional feature macro: SEED_HIT_REARM_EN
//     defined   -> the run restarts after every hit, so an unbroken diagonal yields one
//                  non-overlapping seed per WORD_LEN matches
//     undefined -> the run saturates, giving exactly one hit per unbroken diagonal run
module seed_hit_detector #(
   parameter int LENGTH_COUNTER = 8,
   parameter int WORD_LEN       = 11,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          com_clk,
   input  logic                          reset,
   input  logic                          match,
   input  logic [LENGTH_COUNTER-1:0]     query_id,
   input  logic [LENGTH_COUNTER-1:0]     sub_id,
   output logic                          hit_valid,
   input  logic                          hit_ready,
   output logic [LENGTH_COUNTER-1:0]     hit_query_pos,
   output logic [LENGTH_COUNTER-1:0]     hit_sub_pos,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [LENGTH_COUNTER-1:0] LEN_ZERO   = LENGTH_COUNTER'(0);
   localparam logic [LENGTH_COUNTER-1:0] LEN_ONE    = LENGTH_COUNTER'(1);
   localparam logic [LENGTH_COUNTER-1:0] WORD_LEN_C = LENGTH_COUNTER'(WORD_LEN);
   localparam logic [LENGTH_COUNTER-1:0] OFFSET_C   = LENGTH_COUNTER'(WORD_LEN - 1);
   localparam logic [PW-1:0]             PTR_ONE    = PW'(1);
   localparam logic [CW-1:0]             CNT_ZERO   = CW'(0);
   localparam logic [CW-1:0]             CNT_ONE    = CW'(1);
   localparam logic [CW-1:0]             DEPTH_C    = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SEEDED = 2'd2
   } run_state_e;

   run_state_e                  state_q, state_d;
   logic [LENGTH_COUNTER-1:0]   run_len_q, run_len_d;
   logic [LENGTH_COUNTER-1:0]   last_q_q, last_q_d;
   logic [LENGTH_COUNTER-1:0]   last_s_q, last_s_d;
   logic [LENGTH_COUNTER-1:0]   grow_len_s;
   logic [LENGTH_COUNTER-1:0]   next_q_s, next_s_s;
   logic                        diag_s;
   logic                        hit_s;
   logic [LENGTH_COUNTER-1:0]   start_q_s, start_s_s;

   logic [LENGTH_COUNTER-1:0]   fifo_qpos_q [FIFO_DEPTH];
   logic [LENGTH_COUNTER-1:0]   fifo_spos_q [FIFO_DEPTH];
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        overflow_q, overflow_d;
   logic                        pop_s, push_s, full_s;

   // Run tracker next state: diagonal continuity check, run length update, hit event.
   always_comb begin
      state_d    = state_q;
      run_len_d  = run_len_q;
      last_q_d   = last_q_q;
      last_s_d   = last_s_q;
      grow_len_s = LEN_ONE;
      next_q_s   = last_q_q + LEN_ONE;
      next_s_s   = last_s_q + LEN_ONE;
      diag_s     = (query_id == next_q_s) && (sub_id == next_s_s);
      hit_s      = 1'b0;
      start_q_s  = query_id - OFFSET_C;
      start_s_s  = sub_id - OFFSET_C;

      if (match) begin
         last_q_d = query_id;
         last_s_d = sub_id;
         case (state_q)
            ST_IDLE:   grow_len_s = LEN_ONE;
            ST_RUN:    grow_len_s = diag_s ? (run_len_q + LEN_ONE) : LEN_ONE;
            ST_SEEDED: grow_len_s = diag_s ? WORD_LEN_C : LEN_ONE;
            default:   grow_len_s = LEN_ONE;
         endcase
         run_len_d = grow_len_s;
         // A hit fires only on entering the seeded length, never while held there.
         hit_s     = (grow_len_s == WORD_LEN_C) && (run_len_q != WORD_LEN_C);
      end else begin
         run_len_d = LEN_ZERO;
      end

`ifdef SEED_HIT_REARM_EN
      // Restart so the next WORD_LEN matches form a new, non-overlapping seed.
      if (hit_s) begin
         run_len_d = LEN_ZERO;
      end else begin
         run_len_d = run_len_d;
      end
`endif

      if (run_len_d == LEN_ZERO) begin
         state_d = ST_IDLE;
      end else if (run_len_d == WORD_LEN_C) begin
         state_d = ST_SEEDED;
      end else begin
         state_d = ST_RUN;
      end
   end

   // Run tracker state registers.
   always_ff @(posedge com_clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         run_len_q <= LEN_ZERO;
         last_q_q  <= LEN_ZERO;
         last_s_q  <= LEN_ZERO;
      end else begin
         state_q   <= state_d;
         run_len_q <= run_len_d;
         last_q_q  <= last_q_d;
         last_s_q  <= last_s_d;
      end
   end

   // FIFO control: a full FIFO still accepts a hit when its head leaves the same cycle.
   always_comb begin
      pop_s      = (count_q != CNT_ZERO) && hit_ready;
      full_s     = (count_q == DEPTH_C);
      push_s     = hit_s && (!full_s || pop_s);
      overflow_d = overflow_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (hit_s && full_s && !pop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage, pointers, occupancy and sticky overflow flag.
   always_ff @(posedge com_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_qpos_q[i] <= LEN_ZERO;
            fifo_spos_q[i] <= LEN_ZERO;
         end
         wr_ptr_q   <= PW'(0);
         rd_ptr_q   <= PW'(0);
         count_q    <= CNT_ZERO;
         overflow_q <= 1'b0;
      end else begin
         if (push_s) begin
            fifo_qpos_q[wr_ptr_q] <= start_q_s;
            fifo_spos_q[wr_ptr_q] <= start_s_s;
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign hit_valid     = (count_q != CNT_ZERO);
   assign hit_query_pos = fifo_qpos_q[rd_ptr_q];
   assign hit_sub_pos   = fifo_spos_q[rd_ptr_q];
   assign fifo_count    = count_q;
   assign overflow      = overflow_q;

endmodule
